// File: rtl/uart_pkg.sv
// Shared UART constants: data width and receiver state encodings.
// uart_tx uses UART_DATA_BITS from this package as well.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        BREAK  = ST_BREAK
    } rx_state_t;

    // Even parity holds when the data bits plus the parity bit contain an even number of ones.
    function automatic logic even_parity_ok(input logic [UART_DATA_BITS-1:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 1 (idle line level).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8-bit LSB-first UART receiver with mid-bit sampling and a valid/ready holding register.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rxd,
    output logic [UART_DATA_BITS-1:0] uart_rx_data,
    output logic                      uart_rx_valid,
    input  logic                      uart_rx_ready,
    output logic                      uart_rx_busy,
    output logic                      uart_rx_frame_err,
    output logic                      uart_rx_overrun,
    output logic                      uart_rx_parity_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    logic                      w_rxd_s;
    rx_state_t                 r_state,       w_state_nx;
    logic [CW-1:0]             r_cnt,         w_cnt_nx;
    logic [2:0]                r_bit_idx,     w_bit_idx_nx;
    logic [UART_DATA_BITS-1:0] r_shreg,       w_shreg_nx;
    logic                      r_deliver,     w_deliver_nx;
    logic                      r_frame_err,   w_frame_err_nx;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                      r_parity,      w_parity_nx;
    logic                      r_parity_err,  w_parity_err_nx;
`endif

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_rxd (
        .clk (clk),
        .rst (rst),
        .i_d (uart_rxd),
        .o_q (w_rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity     <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_shreg     <= w_shreg_nx;
            r_deliver   <= w_deliver_nx;
            r_frame_err <= w_frame_err_nx;
`ifdef UART_RX_PARITY_EN
            r_parity     <= w_parity_nx;
            r_parity_err <= w_parity_err_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_bit_idx_nx   = r_bit_idx;
        w_shreg_nx     = r_shreg;
        w_deliver_nx   = 1'b0;
        w_frame_err_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_nx     = r_parity;
        w_parity_err_nx = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_state_nx = START;
                    w_cnt_nx   = '0;
                end
            end
            START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_nx     = '0;
                    w_bit_idx_nx = '0;
                    w_state_nx   = w_rxd_s ? IDLE : DATA;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx              = '0;
                    w_shreg_nx[r_bit_idx] = w_rxd_s;
                    w_bit_idx_nx          = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx    = '0;
                    w_parity_nx = w_rxd_s;
                    w_state_nx  = STOP;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
`endif
            // The trailing half stop bit is skipped so a back-to-back start edge is not missed.
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = '0;
                    if (!w_rxd_s) begin
                        w_frame_err_nx = 1'b1;
                        w_state_nx     = BREAK;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (!even_parity_ok(r_shreg, r_parity)) begin
                        w_parity_err_nx = 1'b1;
                        w_state_nx      = IDLE;
                    end
`endif
                    else begin
                        w_deliver_nx = 1'b1;
                        w_state_nx   = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            BREAK: begin
                if (w_rxd_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // A finished byte lands in the holding register unless an unread byte is still waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || uart_rx_ready) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && uart_rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign uart_rx_data      = r_data;
    assign uart_rx_valid     = r_valid;
    assign uart_rx_busy      = (r_state != IDLE);
    assign uart_rx_frame_err = r_frame_err;
    assign uart_rx_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err = r_parity_err;
`else
    assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level outcome model plus directed checks.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int LATENCY    = 88;
`else
    localparam int FRAME_BITS = 10;
    localparam int LATENCY    = 80;
`endif

    localparam int EV_GOOD = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    typedef struct {
        int         atEdge;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ready;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxBusy;
    logic       rxFrameErr;
    logic       rxOverrun;
    logic       rxParityErr;

    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    int         ferrSeen = 0;
    int         ovrSeen = 0;
    int         perrSeen = 0;
    bit         compareOn = 1'b0;
    ev_t        evQ[$];
    logic [7:0] recvQ[$];
    logic       expValid = 1'b0;
    logic [7:0] expData = 8'h00;
    logic       expFerr = 1'b0;
    logic       expPerr = 1'b0;
    logic       expOvr = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .uart_rxd           (rxd),
        .uart_rx_data       (rxData),
        .uart_rx_valid      (rxValid),
        .uart_rx_ready      (ready),
        .uart_rx_busy       (rxBusy),
        .uart_rx_frame_err  (rxFrameErr),
        .uart_rx_overrun    (rxOverrun),
        .uart_rx_parity_err (rxParityErr)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame and books its outcome against the edge on which the stop bit gets sampled:
    // sync flops, one edge to leave idle, half a bit to the start sample, then the remaining bits.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parBit);
        int k;
        int stopEdge;
        k = cyc;
        stopEdge = k + SYNC + 1 + HALF + (FRAME_BITS - 1) * CPB;
        if (!stopBit) begin
            evQ.push_back('{stopEdge, EV_FERR, b});
        end
`ifdef UART_RX_PARITY_EN
        else if ((^b) != parBit) begin
            evQ.push_back('{stopEdge, EV_PERR, b});
        end
`endif
        else begin
            evQ.push_back('{stopEdge + 1, EV_GOOD, b});
        end
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            waitCycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = parBit;
        waitCycles(CPB);
`endif
        rxd = stopBit;
        waitCycles(CPB);
    endtask

    task automatic waitValid(input int maxCycles, output int seenEdge);
        seenEdge = -1;
        for (int n = 0; n < maxCycles; n++) begin
            if (rxValid) begin
                seenEdge = cyc;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        fails++;
        $display("[TB] FAIL valid_timeout: no valid within %0d cycles, required valid=1", maxCycles);
    endtask

    // Outcome model: applies booked frame results and the valid/ready handshake at each edge.
    always @(posedge clk) begin
        ev_t        ev;
        logic       deliverNow;
        logic [7:0] deliverByte;
        cyc++;
        deliverNow  = 1'b0;
        deliverByte = 8'h00;
        if (rst) begin
            expValid = 1'b0;
            expData  = 8'h00;
            expFerr  = 1'b0;
            expPerr  = 1'b0;
            expOvr   = 1'b0;
            evQ.delete();
        end else begin
            expFerr = 1'b0;
            expPerr = 1'b0;
            expOvr  = 1'b0;
            if (evQ.size() > 0 && evQ[0].atEdge == cyc) begin
                ev = evQ.pop_front();
                case (ev.kind)
                    EV_GOOD: begin
                        deliverNow  = 1'b1;
                        deliverByte = ev.data;
                    end
                    EV_FERR: expFerr = 1'b1;
                    default: expPerr = 1'b1;
                endcase
            end
            if (deliverNow) begin
                if (!expValid || ready) begin
                    expData  = deliverByte;
                    expValid = 1'b1;
                end else begin
                    expOvr = 1'b1;
                end
            end else if (expValid && ready) begin
                expValid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("valid", int'(rxValid), int'(expValid));
            if (expValid) checkOutput("data", int'(rxData), int'(expData));
            checkOutput("frame_err", int'(rxFrameErr), int'(expFerr));
            checkOutput("overrun", int'(rxOverrun), int'(expOvr));
            checkOutput("parity_err", int'(rxParityErr), int'(expPerr));
            if (rxValid && ready) recvQ.push_back(rxData);
            if (rxFrameErr) ferrSeen++;
            if (rxOverrun) ovrSeen++;
            if (rxParityErr) perrSeen++;
        end
    end

    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        int k;
        int rise;
        rst   = 1'b1;
        rxd   = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", int'(rxValid), 0);
        checkOutput("reset_busy", int'(rxBusy), 0);
        checkOutput("reset_data", int'(rxData), 0);
        checkOutput("reset_pulses", int'({rxFrameErr, rxOverrun, rxParityErr}), 0);
        compareOn = 1'b1;
        rst = 1'b0;
        waitCycles(5);

        $display("[TB] 0x42 latency and single-cycle valid");
        k = cyc;
        fork
            applyStimulus(8'h42, 1'b1, 1'b0);
        join_none
        waitValid(200, rise);
        checkOutput("latency_0x42", rise - k, LATENCY);
        checkOutput("data_0x42", int'(rxData), 8'h42);
        waitCycles(1);
        checkOutput("valid_drop_0x42", int'(rxValid), 0);
        wait fork;
        waitCycles(4);

        $display("[TB] false start");
        rxd = 1'b0;
        waitCycles(2);
        rxd = 1'b1;
        waitCycles(2);
        checkOutput("false_start_busy", int'(rxBusy), 1);
        waitCycles(6);
        checkOutput("false_start_idle", int'(rxBusy), 0);

        $display("[TB] framing error and break");
        applyStimulus(8'h61, 1'b0, 1'b1);
        waitCycles(40);
        checkOutput("break_busy", int'(rxBusy), 1);
        rxd = 1'b1;
        waitCycles(6);
        checkOutput("break_exit", int'(rxBusy), 0);
        applyStimulus(8'h70, 1'b1, 1'b1);
        checkOutput("after_break_valid", int'(rxValid), 1);
        checkOutput("after_break_data", int'(rxData), 8'h70);
        checkOutput("frame_err_count", ferrSeen, 1);
        waitCycles(4);

        $display("[TB] overrun");
        ready = 1'b0;
        applyStimulus(8'h74, 1'b1, 1'b0);
        applyStimulus(8'h65, 1'b1, 1'b0);
        waitCycles(2);
        checkOutput("overrun_keep_data", int'(rxData), 8'h74);
        checkOutput("overrun_count", ovrSeen, 1);
        ready = 1'b1;
        waitCycles(1);
        checkOutput("overrun_valid_drop", int'(rxValid), 0);
        waitCycles(4);

        $display("[TB] back-to-back frames");
        recvQ.delete();
        applyStimulus(8'h20, 1'b1, 1'b1);
        applyStimulus(8'h21, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("b2b_count", recvQ.size(), 2);
        if (recvQ.size() == 2) begin
            checkOutput("b2b_first", int'(recvQ[0]), 8'h20);
            checkOutput("b2b_second", int'(recvQ[1]), 8'h21);
        end

        $display("[TB] reset mid-frame");
        fork
            applyStimulus(8'h0A, 1'b1, 1'b0);
        join_none
        waitCycles(30);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midreset_valid", int'(rxValid), 0);
        checkOutput("midreset_busy", int'(rxBusy), 0);
        checkOutput("midreset_data", int'(rxData), 0);
        checkOutput("midreset_pulses", int'({rxFrameErr, rxOverrun, rxParityErr}), 0);
        wait fork;
        waitCycles(1);
        rst = 1'b0;
        recvQ.delete();
        waitCycles(100);
        checkOutput("midreset_no_byte", recvQ.size(), 0);

        $display("[TB] parity");
`ifdef UART_RX_PARITY_EN
        perrSeen = 0;
        applyStimulus(8'h69, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("parity_err_count", perrSeen, 1);
        checkOutput("parity_err_no_valid", int'(rxValid), 0);
        applyStimulus(8'h69, 1'b1, 1'b0);
        checkOutput("parity_ok_valid", int'(rxValid), 1);
        checkOutput("parity_ok_data", int'(rxData), 8'h69);
`else
        applyStimulus(8'h69, 1'b1, 1'b1);
        checkOutput("no_parity_valid", int'(rxValid), 1);
        checkOutput("no_parity_data", int'(rxData), 8'h69);
        checkOutput("parity_err_never", perrSeen, 0);
`endif
        waitCycles(5);
        compareOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
